// File: rtl/axis_debug_reply_arbiter.sv
// Merges NUM_PORTS byte-wide debug reply streams onto one master stream.
// Round-robin frame-granular arbitration, with a forced abort byte when a granted frame stalls.
module axis_debug_reply_arbiter #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ABORT_BYTE     = 8'hFF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_PORTS-1:0]   i_s_axis_tvalid,
  output logic [NUM_PORTS-1:0]   o_s_axis_tready,
  input  logic [8*NUM_PORTS-1:0] i_s_axis_tdata,
  input  logic [NUM_PORTS-1:0]   i_s_axis_tlast,
  output logic                   o_m_axis_tvalid,
  input  logic                   i_m_axis_tready,
  output logic [7:0]             o_m_axis_tdata,
  output logic                   o_m_axis_tlast,
  output logic [NUM_PORTS-1:0]   o_grant,
  output logic [7:0]             o_timeout_count
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_FLUSH} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   grant_idx, grant_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [CNT_W-1:0]   idle_cnt, idle_nxt;
  logic [7:0]         tmo_nxt;
  logic [IDX_W-1:0]   pick, cand, after_grant;
  logic               found;
  logic               gnt_valid;
  logic [7:0]         port_data [NUM_PORTS];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
    assign port_data[k] = i_s_axis_tdata[8*k +: 8];
  end

  // Owner is a pure function of registered state, so it drops to zero the instant reset asserts.
  assign o_grant     = (state == S_IDLE) ? '0 : (NUM_PORTS'(1) << grant_idx);
  assign gnt_valid   = i_s_axis_tvalid[grant_idx];
  assign after_grant = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise synthesis infers a latch.
    found = 1'b0;
    pick  = rr_ptr;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((rr_ptr + i) % NUM_PORTS);
      if (!found && i_s_axis_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant_idx;
    rr_nxt          = rr_ptr;
    idle_nxt        = idle_cnt;
    tmo_nxt         = o_timeout_count;
    o_m_axis_tvalid = 1'b0;
    o_m_axis_tdata  = '0;
    o_m_axis_tlast  = 1'b0;
    o_s_axis_tready = '0;

    unique case (state)
      S_IDLE: begin
        if (found) begin
          grant_nxt = pick;
          idle_nxt  = '0;
          state_nxt = S_GRANT;
        end
      end

      S_GRANT: begin
        o_m_axis_tvalid = gnt_valid;
        o_m_axis_tdata  = port_data[grant_idx];
        o_m_axis_tlast  = i_s_axis_tlast[grant_idx];
        o_s_axis_tready = o_grant & {NUM_PORTS{i_m_axis_tready}};
        // A byte held under backpressure is not idleness; only an empty granted port ages.
        if (gnt_valid) begin
          idle_nxt = '0;
          if (i_m_axis_tready && i_s_axis_tlast[grant_idx]) begin
            state_nxt = S_IDLE;
            rr_nxt    = after_grant;
          end
        end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_FLUSH;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end

      S_FLUSH: begin
        o_m_axis_tvalid = 1'b1;
        o_m_axis_tdata  = ABORT_BYTE;
        o_m_axis_tlast  = 1'b1;
        if (i_m_axis_tready) begin
          state_nxt = S_IDLE;
          rr_nxt    = after_grant;
          tmo_nxt   = (o_timeout_count == 8'hFF) ? o_timeout_count : o_timeout_count + 8'd1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) begin
      state           <= S_IDLE;
      grant_idx       <= '0;
      rr_ptr          <= '0;
      idle_cnt        <= '0;
      o_timeout_count <= '0;
    end else begin
      state           <= state_nxt;
      grant_idx       <= grant_nxt;
      rr_ptr          <= rr_nxt;
      idle_cnt        <= idle_nxt;
      o_timeout_count <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_axis_debug_reply_arbiter.sv
// Directed bench for axis_debug_reply_arbiter: per-port frame sources with hand-derived expected bytes.
// Source byte k of frame n on port p is {p[1:0], n[1:0], k[3:0]}.
module tb_axis_debug_reply_arbiter;

  localparam int NP  = 4;
  localparam int TMO = 8;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [NP-1:0]   i_s_axis_tvalid, o_s_axis_tready, i_s_axis_tlast, o_grant;
  logic [8*NP-1:0] i_s_axis_tdata;
  logic            o_m_axis_tvalid, i_m_axis_tready, o_m_axis_tlast;
  logic [7:0]      o_m_axis_tdata, o_timeout_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int src_pos[NP], src_len[NP], src_cut[NP], src_frames[NP], src_fdone[NP];
  logic [NP-1:0] acc;
  logic [13:0]   got, exp_v;

  axis_debug_reply_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TMO), .ABORT_BYTE(8'hFF)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_s_axis_tvalid(i_s_axis_tvalid), .o_s_axis_tready(o_s_axis_tready),
    .i_s_axis_tdata(i_s_axis_tdata), .i_s_axis_tlast(i_s_axis_tlast),
    .o_m_axis_tvalid(o_m_axis_tvalid), .i_m_axis_tready(i_m_axis_tready),
    .o_m_axis_tdata(o_m_axis_tdata), .o_m_axis_tlast(o_m_axis_tlast),
    .o_grant(o_grant), .o_timeout_count(o_timeout_count)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish want finish");
    $fatal(1);
  end

  task automatic set_src(input int k, input int len, input int cut, input int frames);
    src_pos[k] = 0; src_fdone[k] = 0; src_len[k] = len; src_cut[k] = cut; src_frames[k] = frames;
  endtask

  task automatic clear_src();
    for (int k = 0; k < NP; k++) set_src(k, 1, 0, 0);
  endtask

  task automatic drive_inputs(input logic mrdy);
    i_m_axis_tready = mrdy;
    for (int k = 0; k < NP; k++) begin
      i_s_axis_tvalid[k]       = (src_frames[k] > 0) && (src_pos[k] < src_cut[k]);
      i_s_axis_tdata[8*k +: 8] = {2'(k), 2'(src_fdone[k]), 4'(src_pos[k])};
      i_s_axis_tlast[k]        = (src_pos[k] == src_len[k] - 1);
    end
  endtask

  // Commit last cycle's accepted bytes at the edge, then present the next cycle mid-low-phase.
  task automatic tick(input logic mrdy);
    @(posedge i_clk);
    for (int k = 0; k < NP; k++) begin
      if (acc[k]) begin
        src_pos[k]++;
        if (src_pos[k] == src_len[k]) begin
          src_pos[k] = 0; src_fdone[k]++; src_frames[k]--;
        end
      end
    end
    @(negedge i_clk);
    drive_inputs(mrdy);
    #1;
    acc = o_s_axis_tready & i_s_axis_tvalid;
  endtask

  task automatic reset_dut();
    i_rst_n = 1'b0;
    clear_src();
    drive_inputs(1'b1);
    acc = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic chk_idle(input string name);
    total_cnt++;
    if ({o_grant, o_m_axis_tvalid} !== 5'b0)
      $display("FAIL %s: got grant=%b valid=%b want grant=0000 valid=0", name, o_grant, o_m_axis_tvalid);
    else pass_cnt++;
  endtask

  task automatic chk_beat(input string name, input logic [3:0] g, input logic l, input logic [7:0] d);
    got   = {o_grant, o_m_axis_tvalid, o_m_axis_tlast, o_m_axis_tdata};
    exp_v = {g, 1'b1, l, d};
    total_cnt++;
    if (got !== exp_v)
      $display("FAIL %s: got {grant,valid,last,data}=%h want %h", name, got, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({o_grant, o_m_axis_tvalid, o_m_axis_tlast} !== 6'b0)
      $display("FAIL reset_master: got grant=%b v=%b l=%b want 0", o_grant, o_m_axis_tvalid, o_m_axis_tlast);
    else pass_cnt++;
    total_cnt++;
    if ({o_s_axis_tready, o_timeout_count} !== 12'h0)
      $display("FAIL reset_slave: got tready=%b tmo=%0d want 0/0", o_s_axis_tready, o_timeout_count);
    else pass_cnt++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_two_ports();
    reset_dut();
    set_src(0, 5, 5, 1);
    set_src(2, 5, 5, 1);
    tick(1'b1); chk_idle("tp_arb");
    for (int b = 0; b < 5; b++) begin
      tick(1'b1); chk_beat("tp_port0", 4'b0001, b == 4, 8'h00 + 8'(b));
    end
    tick(1'b1); chk_idle("tp_dead");
    for (int b = 0; b < 5; b++) begin
      tick(1'b1); chk_beat("tp_port2", 4'b0100, b == 4, 8'h80 + 8'(b));
    end
    tick(1'b1); chk_idle("tp_end");
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int k = 0; k < NP; k++) set_src(k, 3, 3, 4);
    for (int f = 0; f < 16; f++) begin
      tick(1'b1); chk_idle("rr_gap");
      for (int b = 0; b < 3; b++) begin
        tick(1'b1);
        chk_beat("rr_beat", 4'(1 << (f % 4)), b == 2, {2'(f % 4), 2'(f / 4), 4'(b)});
      end
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    set_src(1, 5, 2, 1);
    tick(1'b1); chk_idle("to_arb");
    tick(1'b1); chk_beat("to_b0", 4'b0010, 1'b0, 8'h40);
    tick(1'b1); chk_beat("to_b1", 4'b0010, 1'b0, 8'h41);
    for (int i = 0; i < TMO; i++) begin
      tick(1'b1);
      total_cnt++;
      if ({o_grant, o_m_axis_tvalid} !== 5'b0010_0)
        $display("FAIL to_wait%0d: got grant=%b valid=%b want 0010/0", i, o_grant, o_m_axis_tvalid);
      else pass_cnt++;
    end
    tick(1'b0); chk_beat("to_flush_stall", 4'b0010, 1'b1, 8'hFF);
    tick(1'b1); chk_beat("to_flush_xfer", 4'b0010, 1'b1, 8'hFF);
    total_cnt++;
    if (o_s_axis_tready !== 4'b0000)
      $display("FAIL to_flush_tready: got %b want 0000", o_s_axis_tready);
    else pass_cnt++;
    tick(1'b1); chk_idle("to_after");
    total_cnt++;
    if (o_timeout_count !== 8'd1)
      $display("FAIL to_count: got %0d want 1", o_timeout_count);
    else pass_cnt++;
    set_src(1, 1, 1, 1);
    set_src(2, 1, 1, 1);
    tick(1'b1); chk_idle("to_rearb");
    tick(1'b1); chk_beat("to_next_port2", 4'b0100, 1'b1, 8'h80);
  endtask

  task automatic test_backpressure();
    logic mrdy;
    reset_dut();
    set_src(3, 10, 10, 1);
    tick(1'b1); chk_idle("bp_arb");
    for (int i = 0; i < 19; i++) begin
      mrdy = (i % 2 == 0);
      tick(mrdy);
      chk_beat("bp_beat", 4'b1000, (i + 1) / 2 == 9, 8'hC0 + 8'((i + 1) / 2));
      total_cnt++;
      if (o_s_axis_tready !== {mrdy, 3'b000})
        $display("FAIL bp_tready%0d: got %b want %b", i, o_s_axis_tready, {mrdy, 3'b000});
      else pass_cnt++;
    end
    tick(1'b1); chk_idle("bp_end");
    total_cnt++;
    if (o_timeout_count !== 8'd0)
      $display("FAIL bp_no_timeout: got %0d want 0", o_timeout_count);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    bit seen;
    bit ok = 1'b1;
    int want;
    reset_dut();
    for (int n = 1; n <= 260 && ok; n++) begin
      set_src(0, 2, 1, 1);
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        tick(1'b1);
        if (o_m_axis_tvalid && o_m_axis_tlast && o_m_axis_tdata == 8'hFF && o_grant == 4'b0001) seen = 1'b1;
      end
      if (!seen) begin
        total_cnt++;
        $display("FAIL sat_flush%0d: got no abort byte within 30 cycles want abort byte", n);
        ok = 1'b0;
      end else begin
        tick(1'b1);
        if (n == 1 || n == 254 || n == 255 || n == 256 || n == 260) begin
          want = (n > 255) ? 255 : n;
          total_cnt++;
          if (o_timeout_count !== 8'(want))
            $display("FAIL sat_count%0d: got %0d want %0d", n, o_timeout_count, want);
          else pass_cnt++;
        end
      end
    end
  endtask

  // Runs straight after saturation so the async reset visibly clears a non-zero count.
  task automatic test_reset_midframe();
    set_src(0, 5, 5, 1);
    tick(1'b1); chk_idle("rm_arb");
    tick(1'b1); chk_beat("rm_b0", 4'b0001, 1'b0, 8'h00);
    tick(1'b1); chk_beat("rm_b1", 4'b0001, 1'b0, 8'h01);
    tick(1'b1); chk_beat("rm_b2", 4'b0001, 1'b0, 8'h02);
    i_rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({o_grant, o_m_axis_tvalid, o_m_axis_tlast, o_s_axis_tready, o_timeout_count} !== 18'h0)
      $display("FAIL rm_async: got grant=%b v=%b l=%b tready=%b tmo=%0d want all 0",
               o_grant, o_m_axis_tvalid, o_m_axis_tlast, o_s_axis_tready, o_timeout_count);
    else pass_cnt++;
    clear_src();
    drive_inputs(1'b1);
    acc = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    set_src(1, 1, 1, 1);
    tick(1'b1); chk_idle("rm_post_arb");
    tick(1'b1); chk_beat("rm_post_port1", 4'b0010, 1'b1, 8'h40);
  endtask

  initial begin
    i_s_axis_tvalid = '0;
    i_s_axis_tdata  = '0;
    i_s_axis_tlast  = '0;
    i_m_axis_tready = 1'b1;
    acc             = '0;
    clear_src();
    test_reset();
    test_two_ports();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
